// File: rtl/instruction_fetch_pkg.sv
// Shared widths, constants and the address-validity helper for the instruction fetch block.
package if_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] INVALID_INSTR = 32'h0;
    localparam logic [XLEN-1:0] PC_STEP = 64'd4;

    // top_lsb is the first byte-address bit that lies beyond the memory.
    function automatic logic addr_bad(input logic [XLEN-1:0] addr, input int unsigned top_lsb);
        return (addr[1:0] != 2'b00) || ((addr >> top_lsb) != '0);
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-side bus: PC control inputs, fetched word and PC status.
// The imem_* write signals exist only when IF_IMEM_WR_EN is defined.
interface instruction_fetch_if;
    import if_pkg::*;

    logic            pc_en;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic [ILEN-1:0] instruction;
    logic            invAddr;
    logic [XLEN-1:0] pc_out;
`ifdef IF_IMEM_WR_EN
    logic            imem_we;
    logic [XLEN-1:0] imem_waddr;
    logic [ILEN-1:0] imem_wdata;
`endif

    modport master (
        output pc_en, branch_taken, branch_target,
`ifdef IF_IMEM_WR_EN
        output imem_we, imem_waddr, imem_wdata,
`endif
        input  instruction, invAddr, pc_out
    );

    modport slave (
        input  pc_en, branch_taken, branch_target,
`ifdef IF_IMEM_WR_EN
        input  imem_we, imem_waddr, imem_wdata,
`endif
        output instruction, invAddr, pc_out
    );

endinterface

// File: rtl/instruction_fetch.sv
// PC register plus flat word memory with a combinational fetch path.
// IF_IMEM_WR_EN adds a synchronous memory write port on the bus.
module instruction_fetch
    import if_pkg::*;
#(
    parameter int              MEM_DEPTH = 1024,
    parameter logic [XLEN-1:0] RESET_PC  = 64'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    instruction_fetch_if.slave bus
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic [XLEN-1:0]  PC;
    logic [ILEN-1:0]  instr_mem [0:MEM_DEPTH-1];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             pc_bad;
    logic             mem_we;
    logic [XLEN-1:0]  mem_waddr;
    logic [ILEN-1:0]  mem_wdata;

    // PC keeps moving even when it points outside the memory; faults are handled downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC <= RESET_PC;
        end else if (bus.pc_en) begin
            PC <= bus.branch_taken ? bus.branch_target : PC + PC_STEP;
        end
    end

    assign rd_idx          = PC[IDX_W+1:2];
    assign pc_bad          = addr_bad(PC, IDX_W + 2);
    assign bus.invAddr     = pc_bad;
    assign bus.instruction = pc_bad ? INVALID_INSTR : instr_mem[rd_idx];
    assign bus.pc_out      = PC;

`ifdef IF_IMEM_WR_EN
    assign mem_we    = bus.imem_we;
    assign mem_waddr = bus.imem_waddr;
    assign mem_wdata = bus.imem_wdata;
`else
    // No write port: the memory is filled hierarchically or by an initial load.
    assign mem_we    = 1'b0;
    assign mem_waddr = '0;
    assign mem_wdata = '0;
`endif

    assign wr_idx = mem_waddr[IDX_W+1:2];

    // No reset on the array: program contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we && !addr_bad(mem_waddr, IDX_W + 2)) begin
            instr_mem[wr_idx] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus queues expected outputs, a negedge monitor checks them.
module tb_instruction_fetch;
    import if_pkg::*;

    logic clk;
    logic rst_n;
    logic [63:0] fpc;

    instruction_fetch_if bus();

    instruction_fetch #(.MEM_DEPTH(1024), .RESET_PC(64'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        inv;
        logic [63:0] pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            total++;
            if (bus.instruction !== mon_e.instr || bus.invAddr !== mon_e.inv || bus.pc_out !== mon_e.pc) begin
                bad++;
                $display("FAIL %s: got instr=%h inv=%b pc=%h, want instr=%h inv=%b pc=%h",
                         mon_e.name, bus.instruction, bus.invAddr, bus.pc_out,
                         mon_e.instr, mon_e.inv, mon_e.pc);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] ins, input logic inv, input logic [63:0] pc);
        exp_t e;
        int n;
        e.name = name; e.instr = ins; e.inv = inv; e.pc = pc;
        exp_q.push_back(e);
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL %s: monitor never sampled, pending=%0d want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic forced(input string name, input logic [63:0] pc, input logic [31:0] ins, input logic inv);
        fpc = pc;
        force dut.PC = fpc;
        #1;
        chk(name, ins, inv, pc);
        release dut.PC;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t limit=100000", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.pc_en = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = '0;
`ifdef IF_IMEM_WR_EN
        bus.imem_we = 1'b0;
        bus.imem_waddr = '0;
        bus.imem_wdata = '0;
`endif
        for (int i = 0; i < 1024; i++) dut.instr_mem[i] = 32'h0;
        dut.instr_mem[0]    = 32'h0123_4567;
        dut.instr_mem[1]    = 32'h89AB_CDEF;
        dut.instr_mem[2]    = 32'hFEDC_BA98;
        dut.instr_mem[3]    = 32'h7654_3210;
        dut.instr_mem[64]   = 32'h1357_9BDF;
        dut.instr_mem[1023] = 32'hDEAD_BEEF;

        #1;
        chk("reset_state", 32'h0123_4567, 1'b0, 64'h0);
        step();
        rst_n = 1'b1;

        forced("read_0x0", 64'h0, 32'h0123_4567, 1'b0);
        forced("read_0x4", 64'h4, 32'h89AB_CDEF, 1'b0);
        forced("read_0x8", 64'h8, 32'hFEDC_BA98, 1'b0);
        forced("read_0xC", 64'hC, 32'h7654_3210, 1'b0);
        forced("high_bit_0x10", 64'h1000_0000_0000_0010, 32'h0, 1'b1);
        forced("high_bit_0x14", 64'h1000_0000_0000_0014, 32'h0, 1'b1);
        forced("misaligned_0x6", 64'h6, 32'h0, 1'b1);
        forced("last_word_0xFFC", 64'hFFC, 32'hDEAD_BEEF, 1'b0);
        forced("first_oob_0x1000", 64'h1000, 32'h0, 1'b1);

        rst_n = 1'b0;
        #1;
        chk("reset_after_force", 32'h0123_4567, 1'b0, 64'h0);
        step();
        rst_n = 1'b1;

        bus.pc_en = 1'b1;
        step(); chk("inc_1", 32'h89AB_CDEF, 1'b0, 64'h4);
        step(); chk("inc_2", 32'hFEDC_BA98, 1'b0, 64'h8);
        step(); chk("inc_3", 32'h7654_3210, 1'b0, 64'hC);
        bus.pc_en = 1'b0;
        step(); chk("hold_1", 32'h7654_3210, 1'b0, 64'hC);
        bus.branch_taken = 1'b1;
        bus.branch_target = 64'h100;
        step(); chk("hold_branch_ignored", 32'h7654_3210, 1'b0, 64'hC);

        bus.pc_en = 1'b1;
        step(); chk("branch_0x100", 32'h1357_9BDF, 1'b0, 64'h100);
        bus.branch_target = 64'h102;
        step(); chk("branch_misaligned", 32'h0, 1'b1, 64'h102);
        bus.branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        step(); chk("branch_top", 32'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        bus.branch_taken = 1'b0;
        step(); chk("wrap_to_0", 32'h0123_4567, 1'b0, 64'h0);

        bus.branch_taken = 1'b1;
        bus.branch_target = 64'h100;
        step();
        bus.pc_en = 1'b0;
        bus.branch_taken = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 32'h0123_4567, 1'b0, 64'h0);

        bus.pc_en = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_target = 64'h100;
        step(); chk("reset_overrides_branch", 32'h0123_4567, 1'b0, 64'h0);
        bus.pc_en = 1'b0;
        bus.branch_taken = 1'b0;
        rst_n = 1'b1;

`ifdef IF_IMEM_WR_EN
        fpc = 64'h28;
        force dut.PC = fpc;
        #1;
        chk("pre_write_0x28", 32'h0, 1'b0, 64'h28);
        bus.imem_we = 1'b1;
        bus.imem_waddr = 64'h28;
        bus.imem_wdata = 32'hAABB_CCDD;
        step();
        bus.imem_we = 1'b0;
        chk("write_0x28", 32'hAABB_CCDD, 1'b0, 64'h28);
        bus.imem_we = 1'b1;
        bus.imem_waddr = 64'h2A;
        bus.imem_wdata = 32'h1111_1111;
        step();
        bus.imem_waddr = 64'h1028;
        step();
        bus.imem_we = 1'b0;
        chk("bad_writes_ignored", 32'hAABB_CCDD, 1'b0, 64'h28);
        release dut.PC;
`endif

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
